imem_fetch_unit: RTL and testbench

Instruction fetch initiator that drives the instruction memory's `readEnable`/`address` port. It holds the program counter and issues one word request per cycle. It tracks the memory's fixed one-cycle read latency and buffers returned words with their PCs in a small FIFO. Words go to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and handles branch/jump redirects from execute by flushing all stale fetches.

---
 rtl/imem_fetch_unit.sv | 134 +++++++++++++
 tb/tb_imem_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Instruction fetch initiator: issues one word request per cycle to a 1-cycle-latency
// instruction memory, buffers {instruction, pc} in a small FIFO and hands words to decode.
module imem_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0100_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h1111_1111,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read_enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_q, pc_d;
  logic         req_v_q, req_v_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         rsp_v_q, rsp_v_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic         fault_q, fault_d;
  fetch_entry_t fifo_q [FIFO_DEPTH];

  logic             pop_c;
  logic             push_c;
  logic             issue_c;
  logic [CRD_W-1:0] credit_c;
  fetch_entry_t     head_c;

  // Occupancy once everything already in flight has landed; never exceeds the FIFO.
  always_comb begin
    pop_c    = (count_q != '0) && out_ready;
    push_c   = rsp_v_q;
    credit_c = CRD_W'(count_q) + CRD_W'(req_v_q) + CRD_W'(rsp_v_q) - CRD_W'(pop_c);
    issue_c  = !fault_q && (credit_c < CRD_W'(FIFO_DEPTH));
  end

  // Next-state logic; a redirect flushes the FIFO and drops the outstanding response.
  always_comb begin
    pc_d     = pc_q;
    req_v_d  = 1'b0;
    req_pc_d = req_pc_q;
    rsp_v_d  = req_v_q;
    rsp_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fault_d  = fault_q;
    if (redirect_valid) begin
      rsp_v_d  = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        req_v_d  = 1'b1;
        req_pc_d = redirect_pc;
        pc_d     = redirect_pc + 32'd4;
        fault_d  = 1'b0;
      end else begin
        fault_d  = 1'b1;
        pc_d     = redirect_pc;
      end
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      if (issue_c) begin
        req_v_d  = 1'b1;
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_v_q  <= 1'b0;
      req_pc_q <= RESET_PC;
      rsp_v_q  <= 1'b0;
      rsp_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_v_q  <= req_v_d;
      req_pc_q <= req_pc_d;
      rsp_v_q  <= rsp_v_d;
      rsp_pc_q <= rsp_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else if (push_c && !redirect_valid) begin
      fifo_q[wr_ptr_q] <= '{instr: imem_instruction, pc: rsp_pc_q};
    end
  end

  assign head_c           = fifo_q[rd_ptr_q];
  assign imem_read_enable = req_v_q;
  assign imem_address     = req_pc_q;
  assign out_valid        = (count_q != '0);
  assign out_instruction  = out_valid ? head_c.instr : NOP_INSTRUCTION;
  assign out_pc           = out_valid ? head_c.pc : 32'h0;
  assign fetch_fault      = fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed scenarios plus random ready/redirect/reset traffic,
// checked against an in-order stream model (expected next pc, fault flag, memory contents).
module tb_imem_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam logic [31:0] NOP      = 32'h1111_1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read_enable;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_pops  = 0;
  logic [31:0] exp_pc;
  logic        m_fault;

  imem_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_read_enable (imem_read_enable),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .fetch_fault      (fetch_fault)
  );

  always #5 clk = ~clk;

  // Program lives in 0x01000000..0x01000FFF; everything else reads as NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:12] == 20'h01000) return {~a[15:0], a[15:0]};
    return NOP;
  endfunction

  // Memory with a fixed one-cycle read latency.
  initial imem_instruction = NOP;
  always @(posedge clk) begin
    if (imem_read_enable) imem_instruction <= mem_word(imem_address);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: score the handshake about to happen, advance, then check invariants.
  task automatic cycle();
    if (rst_n) begin
      if (redirect_valid) begin
        exp_pc  = redirect_pc;
        m_fault = (redirect_pc[1:0] != 2'b00);
      end else if (out_valid && out_ready) begin
        check("pop_pc", 64'(out_pc), 64'(exp_pc));
        check("pop_ins", 64'(out_instruction), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        n_pops++;
      end
    end
    @(posedge clk);
    #1;
    check("fault", 64'(fetch_fault), 64'(m_fault));
    if (m_fault) begin
      check("fault_re", 64'(imem_read_enable), 64'd0);
      check("fault_ov", 64'(out_valid), 64'd0);
    end
    if (!out_valid) check("idle_out", {out_pc, out_instruction}, {32'h0, NOP});
  endtask

  task automatic check_reset_values();
    check("rst_re",   64'(imem_read_enable), 64'd0);
    check("rst_addr", 64'(imem_address), 64'(RESET_PC));
    check("rst_ov",   64'(out_valid), 64'd0);
    check("rst_out",  {out_pc, out_instruction}, {32'h0, NOP});
    check("rst_flt",  64'(fetch_fault), 64'd0);
  endtask

  // Asynchronous reset pulse, checked before any clock edge arrives.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_pc  = RESET_PC;
    m_fault = 1'b0;
  endtask

  // Reset release to first valid output: E0 issue, E1 memory, E2 FIFO write.
  task automatic startup_latency();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (i == 0) check("e0_req", {31'h0, imem_read_enable, imem_address}, {31'h0, 1'b1, RESET_PC});
      check("start_ov", 64'(out_valid), (i == 2) ? 64'd1 : 64'd0);
    end
    check("start_pc", 64'(out_pc), 64'(RESET_PC));
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    exp_pc = RESET_PC;
    m_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Startup and sustained throughput
    startup_latency();
    repeat (8) begin
      cycle();
      check("thru_ov", 64'(out_valid), 64'd1);
    end

    // Backpressure fills the buffer, then drains without gaps
    out_ready = 1'b0;
    repeat (10) cycle();
    check("bp_re", 64'(imem_read_enable), 64'd0);
    check("bp_head", {31'h0, out_valid, out_pc}, {31'h0, 1'b1, exp_pc});
    out_ready = 1'b1;
    cycle();
    check("bp_resume", {31'h0, imem_read_enable, imem_address}, {31'h0, 1'b1, exp_pc + 32'd12});
    repeat (8) begin
      cycle();
      check("bp_nogap", 64'(out_valid), 64'd1);
    end

    // Redirect with requests in flight and a pop on the same edge
    check("pre_rdr", {out_valid, imem_read_enable}, 64'd3);
    redirect(32'h0100_0100);
    check("rdr_req", {31'h0, imem_read_enable, imem_address}, {31'h0, 1'b1, 32'h0100_0100});
    check("rdr_ov0", 64'(out_valid), 64'd0);
    cycle();
    check("rdr_ov1", 64'(out_valid), 64'd0);
    cycle();
    check("rdr_out", {31'h0, out_valid, out_pc}, {31'h0, 1'b1, 32'h0100_0100});
    repeat (4) cycle();

    // Misaligned redirect halts fetch; aligned redirect recovers
    redirect(32'h0100_0102);
    repeat (5) cycle();
    redirect(32'h0100_0200);
    check("rec_req", {31'h0, imem_read_enable, imem_address}, {31'h0, 1'b1, 32'h0100_0200});
    repeat (2) cycle();
    check("rec_out", {31'h0, out_valid, out_pc}, {31'h0, 1'b1, 32'h0100_0200});
    repeat (3) cycle();

    // Address wrap, unmapped words read as NOP
    redirect(32'hFFFF_FFFC);
    cycle();
    cycle();
    check("wrap0", {out_pc, out_instruction}, {32'hFFFF_FFFC, NOP});
    cycle();
    check("wrap1", {out_pc, out_instruction}, {32'h0, NOP});
    repeat (3) cycle();

    // Mid-stream reset restarts at RESET_PC
    redirect(32'h0100_0040);
    repeat (3) cycle();
    do_reset();
    startup_latency();
    repeat (4) cycle();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      int unsigned r;
      r = $urandom_range(0, 199);
      if (r < 2) begin
        do_reset();
      end else begin
        redirect_valid = (r < 8);
        case ($urandom_range(0, 9))
          0:       redirect_pc = RESET_PC + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(1, 3));
          1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
          default: redirect_pc = RESET_PC + 32'($urandom_range(0, 1023) * 4);
        endcase
        out_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end
    redirect_valid = 1'b0;
    check("progress", 64'(n_pops >= 150), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
